cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
- Microcode sequencer for the 8-bit bus CPU. Walks the fetch/execute T-states and drives the 15-bit active-mixed control word into the PC, MAR, RAM, IR, A, B, ALU and output register.
- Adds run/single-step gating, a sticky halt and variable-length instructions.
- Sits between the instruction register opcode and the datapath control pins.

Parameters:
- IDLE_WORD, 15'h0FE3, control word with every load/enable inactive.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  4  instruction register opcode; valid from T2 onward.
- zf  input  1  ALU zero flag; used only with the optional feature.
- cf  input  1  ALU carry flag; used only with the optional feature.
- run  input  1  level: 1 means free-running execution.
- step  input  1  single-cycle pulse: execute one instruction while run=0.
- control  output  15  bits 14..0 = Cp Ep Lp nLma nLmd nCE nLr nLi nEi nLa Ea sub Eu nLb nLo.
- t_state  output  3  current T index 0..4; 7 in WAIT/HALT.
- instr_done  output  1  high during the final T-state cycle of each instruction.
- halted  output  1  high while in HALT.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset, applied at any time including mid-instruction:
  - state=WAIT, step_pending=0.
  - control=IDLE_WORD, t_state=7, instr_done=0, halted=0.
- States: WAIT, T0, T1, T2, T3, T4, HALT. Register state and step_pending.
- control, t_state and instr_done are combinational from the state register and opcode only.
- step handling:
  - step=1 sets step_pending.
  - step_pending clears on the WAIT->T0 transition.
  - Extra step pulses while pending, or during an instruction, are ignored.
- WAIT: control=IDLE_WORD. Moves to T0 when run=1 or step_pending=1.
- T0: Ep=1, nLma=0 (PC -> MAR), word 0x27E3. Next state T1.
- T1: nCE=0, nLi=0, Cp=1 (RAM -> IR, PC++), word 0x4D63. Next state T2.
- Opcode map (unlisted opcodes are NOP):
  - 0x0 NOP; 0x1 LDA; 0x2 ADD; 0x3 SUB; 0x4 STA; 0x5 LDI; 0x6 JMP; 0x7 JC; 0x8 JZ; 0xE OUT; 0xF HLT.
- Execute steps (fields not listed stay inactive):
  - LDA: T2 nEi=0,nLma=0 (0x07A3); T3 nCE=0,nLa=0 (0x0DC3), last.
  - ADD: T2 as LDA; T3 nCE=0,nLb=0 (0x0DE1); T4 Eu=1,nLa=0 (0x0FC7), last.
  - SUB: as ADD, but T4 also sub=1 (0x0FCF).
  - STA: T2 as LDA; T3 Ea=1,nLmd=0 (0x0BF3); T4 nLr=0 (0x0EE3), last.
  - LDI: T2 nEi=0,nLa=0 (0x0F83), last.
  - JMP: T2 nEi=0,Lp=1 (0x1FA3), last.
  - OUT: T2 Ea=1,nLo=0 (0x0FF2), last.
  - NOP and JC/JZ without the optional feature: T2 = IDLE_WORD, last.
  - HLT: T2 = IDLE_WORD, last. Next state is HALT regardless of run.
- After the last step: T0 if run=1 (no bubble), otherwise WAIT.
- instr_done=1 in that last cycle, and in the HLT T2 cycle.
- HALT: control=IDLE_WORD, halted=1. Sticky until rst; run and step are ignored.
- run dropping mid-instruction: the current instruction completes, then the sequencer stops in WAIT.

Optional Feature:
- Macro: SEQ_COND_JMP_EN.
- Defined:
  - JC (0x7): T2 = 0x1FA3 if cf=1, else IDLE_WORD.
  - JZ (0x8): T2 = 0x1FA3 if zf=1, else IDLE_WORD.
  - Flags are sampled combinationally in T2. T2 is the last step in both cases.
- Undefined: 0x7 and 0x8 decode as NOP; zf and cf are unused.

Test Plan:
- Reset, run=0, no step for 10 cycles -> control=0x0FE3, t_state=7, halted=0 throughout.
- run=1, opcode=0x2 -> per-cycle control 0x27E3, 0x4D63, 0x07A3, 0x0DE1, 0x0FC7 (instr_done=1), then 0x27E3.
- run=0, one step pulse, opcode=0xE -> WAIT, then 0x27E3, 0x4D63, 0x0FF2 (instr_done), then 0x0FE3 held. A second step pulse during T1 is ignored.
- run=1, opcode=0xF -> reaches HALT with halted=1, control=0x0FE3. Toggling run and step has no effect; rst returns to WAIT.
- rst asserted mid-T3 of LDA -> control=0x0FE3 immediately (asynchronous). With run=1, after release, WAIT then T0.
- With SEQ_COND_JMP_EN: opcode=0x8, zf=1 -> T2 control=0x1FA3; zf=0 -> 0x0FE3. Without the macro -> 0x0FE3 for both.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Microcode sequencer: walks fetch/execute T-states and drives the 15-bit control word.
// Optional conditional jumps (JC/JZ) are enabled with `define SEQ_COND_JMP_EN.
module cpu_sequencer #(
    parameter logic [14:0] IDLE_WORD = 15'h0FE3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        zf,
    input  logic        cf,
    input  logic        run,
    input  logic        step,
    output logic [14:0] control,
    output logic [2:0]  t_state,
    output logic        instr_done,
    output logic        halted
);

    // state | meaning
    // T0    | PC -> MAR
    // T1    | RAM -> IR, PC++
    // T2-T4 | opcode-dependent execute steps
    // HALT  | sticky stop after HLT, left only by rst
    // WAIT  | idle, waiting for run or a pending step
    typedef enum logic [2:0] {
        S_T0   = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_HALT = 3'd6,
        S_WAIT = 3'd7
    } state_t;

    localparam logic [14:0] W_FETCH_ADDR = 15'h27E3;
    localparam logic [14:0] W_FETCH_IR   = 15'h4D63;
    localparam logic [14:0] W_IR_TO_MAR  = 15'h07A3;
    localparam logic [14:0] W_RAM_TO_A   = 15'h0DC3;
    localparam logic [14:0] W_RAM_TO_B   = 15'h0DE1;
    localparam logic [14:0] W_ALU_ADD    = 15'h0FC7;
    localparam logic [14:0] W_ALU_SUB    = 15'h0FCF;
    localparam logic [14:0] W_A_TO_MDR   = 15'h0BF3;
    localparam logic [14:0] W_MDR_TO_RAM = 15'h0EE3;
    localparam logic [14:0] W_IR_TO_A    = 15'h0F83;
    localparam logic [14:0] W_IR_TO_PC   = 15'h1FA3;
    localparam logic [14:0] W_A_TO_OUT   = 15'h0FF2;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t state_q, state_d;
    logic   step_pending_q, step_pending_d;

`ifndef SEQ_COND_JMP_EN
    logic unused_flags;
    assign unused_flags = zf ^ cf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_WAIT;
            step_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_pending_q <= step_pending_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        step_pending_d = step_pending_q;
        case (state_q)
            S_WAIT: begin
                if (run || step_pending_q) begin
                    state_d        = S_T0;
                    step_pending_d = 1'b0;
                end else if (step) begin
                    step_pending_d = 1'b1;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T2;
            S_T2, S_T3, S_T4: begin
                if (!instr_done) begin
                    state_d = state_t'(state_q + 3'd1);
                end else if (state_q == S_T2 && opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else if (run) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_WAIT;
        endcase
    end

    // Outputs depend only on state and opcode (plus flags in T2 for conditional jumps).
    always_comb begin
        control    = IDLE_WORD;
        t_state    = 3'd7;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_T0: begin
                t_state = 3'd0;
                control = W_FETCH_ADDR;
            end
            S_T1: begin
                t_state = 3'd1;
                control = W_FETCH_IR;
            end
            S_T2: begin
                t_state    = 3'd2;
                instr_done = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        control    = W_IR_TO_MAR;
                        instr_done = 1'b0;
                    end
                    OP_LDI: control = W_IR_TO_A;
                    OP_JMP: control = W_IR_TO_PC;
                    OP_OUT: control = W_A_TO_OUT;
`ifdef SEQ_COND_JMP_EN
                    OP_JC:  control = cf ? W_IR_TO_PC : IDLE_WORD;
                    OP_JZ:  control = zf ? W_IR_TO_PC : IDLE_WORD;
`endif
                    default: control = IDLE_WORD;
                endcase
            end
            S_T3: begin
                t_state    = 3'd3;
                instr_done = 1'b1;
                case (opcode)
                    OP_LDA: control = W_RAM_TO_A;
                    OP_ADD, OP_SUB: begin
                        control    = W_RAM_TO_B;
                        instr_done = 1'b0;
                    end
                    OP_STA: begin
                        control    = W_A_TO_MDR;
                        instr_done = 1'b0;
                    end
                    default: control = IDLE_WORD;
                endcase
            end
            S_T4: begin
                t_state    = 3'd4;
                instr_done = 1'b1;
                case (opcode)
                    OP_ADD:  control = W_ALU_ADD;
                    OP_SUB:  control = W_ALU_SUB;
                    OP_STA:  control = W_MDR_TO_RAM;
                    default: control = IDLE_WORD;
                endcase
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
